// File: rtl/ctu_clk_pkg.sv
// Shared types and default constants for the CTU clock-driver sequencing logic.
// No logic; types only.
// No flow control.
package ctu_clk_pkg;

    typedef enum logic [2:0] {
        OFF     = 3'd0,
        SETTLE  = 3'd1,
        RAMP_UP = 3'd2,
        ON      = 3'd3,
        RAMP_DN = 3'd4
    } ctu_seq_state_e;

    localparam int CTU_2XDRV_NUM   = 5;
    localparam int CTU_LOCK_CYC    = 512;
    localparam int CTU_STAGGER_CYC = 4;

endpackage

// File: rtl/ctu_sync2.sv
// Generic two-flop synchronizer for a single-bit asynchronous level.
// Latency: 2 clk cycles.
// No flow control; the input is a level, not a transaction.
module ctu_sync2 (
    input  logic clk,
    input  logic rst_l,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ctu_2xclk_drv_seq.sv
// Staggered enable/disable sequencer for the CTU 2x-clock local driver bank.
// Latency: LOCK_CYC+1 cycles from start to first enable, then STAGGER_CYC per driver.
// No backpressure: start/stop are single-cycle pulses, lock loss forces all drivers off.
module ctu_2xclk_drv_seq
    import ctu_clk_pkg::*;
#(
    parameter int NUM_DRV     = CTU_2XDRV_NUM,
    parameter int LOCK_CYC    = CTU_LOCK_CYC,
    parameter int STAGGER_CYC = CTU_STAGGER_CYC,
    parameter int CNT_W       = 10
) (
    input  logic               clk,
    input  logic               rst_l,
    input  logic               pll_lock,
    input  logic               start_req,
    input  logic               stop_req,
    output logic [NUM_DRV-1:0] drv_en,
    output logic               seq_busy,
    output logic               seq_done,
    output logic               lock_err
);

    localparam int IDX_W = (NUM_DRV > 1) ? $clog2(NUM_DRV) : 1;
    localparam logic [CNT_W-1:0] LOCK_RLD = CNT_W'(LOCK_CYC - 1);
    localparam logic [CNT_W-1:0] STAG_RLD = CNT_W'(STAGGER_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DRV - 1);

    ctu_seq_state_e     state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_dec;
    logic [IDX_W-1:0]   idx_q, idx_d, idx_inc, idx_dec;
    logic [NUM_DRV-1:0] drv_d;
    logic               busy_d, done_d, err_d;
    logic               lock_s;

    ctu_sync2 u_lock_sync (
        .clk   (clk),
        .rst_l (rst_l),
        .d     (pll_lock),
        .q     (lock_s)
    );

    assign cnt_dec = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
    assign idx_inc = idx_q + 1'b1;
    assign idx_dec = idx_q - 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_dec;
        idx_d   = idx_q;
        drv_d   = drv_en;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            OFF: begin
                cnt_d = '0;
                // A simultaneous stop wins, so start+stop together is a no-op.
                if (start_req && !stop_req) begin
                    if (lock_s) begin
                        state_d = SETTLE;
                        cnt_d   = LOCK_RLD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d  = RAMP_UP;
                    drv_d[0] = 1'b1;
                    idx_d    = '0;
                    cnt_d    = STAG_RLD;
                end
            end
            RAMP_UP: begin
                if (stop_req) begin
                    state_d      = RAMP_DN;
                    drv_d[idx_q] = 1'b0;
                    cnt_d        = STAG_RLD;
                end else if (cnt_q == '0) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = ON;
                        done_d  = 1'b1;
                    end else begin
                        idx_d          = idx_inc;
                        drv_d[idx_inc] = 1'b1;
                        cnt_d          = STAG_RLD;
                    end
                end
            end
            ON: begin
                drv_d = '1;
                if (stop_req) begin
                    state_d          = RAMP_DN;
                    drv_d[NUM_DRV-1] = 1'b0;
                    idx_d            = IDX_LAST;
                    cnt_d            = STAG_RLD;
                end
            end
            RAMP_DN: begin
                if (cnt_q == '0) begin
                    if (idx_q == '0) begin
                        state_d = OFF;
                        done_d  = 1'b1;
                    end else begin
                        idx_d          = idx_dec;
                        drv_d[idx_dec] = 1'b0;
                        cnt_d          = STAG_RLD;
                    end
                end
            end
            default: begin
                state_d = OFF;
                drv_d   = '0;
            end
        endcase
        // Lock loss overrides everything: hard shutdown, no orderly ramp.
        if (state_q != OFF && !lock_s) begin
            state_d = OFF;
            drv_d   = '0;
            cnt_d   = '0;
            idx_d   = '0;
            done_d  = 1'b0;
            err_d   = 1'b1;
        end
        busy_d = (state_d == SETTLE) || (state_d == RAMP_UP) || (state_d == RAMP_DN);
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q  <= OFF;
            cnt_q    <= '0;
            idx_q    <= '0;
            drv_en   <= '0;
            seq_busy <= 1'b0;
            seq_done <= 1'b0;
            lock_err <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            drv_en   <= drv_d;
            seq_busy <= busy_d;
            seq_done <= done_d;
            lock_err <= err_d;
        end
    end

endmodule

// File: tb/tb_ctu_2xclk_drv_seq.sv
// Scoreboard bench for the 2x-clock driver sequencer: expected enable edges and
// pulses are queued with their cycle when stimulus is driven, then matched as they appear.
module tb_ctu_2xclk_drv_seq;

    localparam int NUM_DRV     = 5;
    localparam int LOCK_CYC    = 8;
    localparam int STAGGER_CYC = 4;

    logic               clk       = 1'b0;
    logic               rst_l     = 1'b0;
    logic               pll_lock  = 1'b0;
    logic               start_req = 1'b0;
    logic               stop_req  = 1'b0;
    logic [NUM_DRV-1:0] drv_en;
    logic               seq_busy;
    logic               seq_done;
    logic               lock_err;

    always #5 clk = ~clk;

    ctu_2xclk_drv_seq #(
        .NUM_DRV     (NUM_DRV),
        .LOCK_CYC    (LOCK_CYC),
        .STAGGER_CYC (STAGGER_CYC),
        .CNT_W       (10)
    ) dut (
        .clk       (clk),
        .rst_l     (rst_l),
        .pll_lock  (pll_lock),
        .start_req (start_req),
        .stop_req  (stop_req),
        .drv_en    (drv_en),
        .seq_busy  (seq_busy),
        .seq_done  (seq_done),
        .lock_err  (lock_err)
    );

    typedef struct {
        int                 cyc;
        logic [NUM_DRV-1:0] val;
    } drv_ev_t;

    drv_ev_t            exp_drv[$];
    int                 exp_done[$];
    int                 exp_err[$];
    int                 cyc      = 0;
    int                 n_checks = 0;
    int                 n_errors = 0;
    int                 busy_cnt = 0;
    bit                 mon_en   = 1'b0;
    logic [NUM_DRV-1:0] prev_drv = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        drv_ev_t e;
        if (mon_en) begin
            if (drv_en !== prev_drv) begin
                if (exp_drv.size() == 0) begin
                    check("drv_unexpected", 32'(drv_en), 32'(prev_drv));
                end else begin
                    e = exp_drv.pop_front();
                    check("drv_val", 32'(drv_en), 32'(e.val));
                    check("drv_cyc", 32'(cyc), 32'(e.cyc));
                end
            end
            if (seq_done !== 1'b0) begin
                if (exp_done.size() == 0) check("done_unexpected", 32'(seq_done), 32'd0);
                else check("done_cyc", 32'(cyc), 32'(exp_done.pop_front()));
            end
            if (lock_err !== 1'b0) begin
                if (exp_err.size() == 0) check("err_unexpected", 32'(lock_err), 32'd0);
                else check("err_cyc", 32'(cyc), 32'(exp_err.pop_front()));
            end
            if (seq_busy === 1'b1) busy_cnt++;
        end
        prev_drv = drv_en;
    end

    task automatic go_to(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start_req = 1'b1;
        @(posedge clk);
        #1;
        start_req = 1'b0;
    endtask

    task automatic pulse_stop();
        stop_req = 1'b1;
        @(posedge clk);
        #1;
        stop_req = 1'b0;
    endtask

    // Ramp-up edges for a start sampled at cycle c0; optionally the ON done pulse.
    task automatic push_up(input int c0, input int steps, input bit with_done);
        drv_ev_t e;
        for (int k = 0; k < steps; k++) begin
            e.cyc = c0 + LOCK_CYC + 1 + k * STAGGER_CYC;
            e.val = NUM_DRV'((1 << (k + 1)) - 1);
            exp_drv.push_back(e);
        end
        if (with_done) exp_done.push_back(c0 + LOCK_CYC + 1 + NUM_DRV * STAGGER_CYC);
    endtask

    task automatic push_drv(input int c, input logic [NUM_DRV-1:0] v);
        drv_ev_t e;
        e.cyc = c;
        e.val = v;
        exp_drv.push_back(e);
    endtask

    task automatic expect_drained(input string tag);
        check({tag, "_drv_pending"},  32'(exp_drv.size()),  32'd0);
        check({tag, "_done_pending"}, 32'(exp_done.size()), 32'd0);
        check({tag, "_err_pending"},  32'(exp_err.size()),  32'd0);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin : stim
        int c0;
        pll_lock = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_drv_en", 32'(drv_en), 32'd0);
        check("rst_busy",   32'(seq_busy), 32'd0);
        check("rst_done",   32'(seq_done), 32'd0);
        check("rst_err",    32'(lock_err), 32'd0);
        rst_l  = 1'b1;
        mon_en = 1'b1;
        go_to(cyc + 3);

        // 1: full ramp-up
        c0 = cyc;
        busy_cnt = 0;
        push_up(c0, NUM_DRV, 1'b1);
        pulse_start();
        go_to(c0 + 32);
        check("s1_busy_cycles", 32'(busy_cnt), 32'd28);
        check("s1_on_drv", 32'(drv_en), 32'h1f);
        expect_drained("s1");

        // 2: full ramp-down from ON
        c0 = cyc;
        busy_cnt = 0;
        for (int k = 1; k <= NUM_DRV; k++)
            push_drv(c0 + 1 + (k - 1) * STAGGER_CYC, NUM_DRV'((1 << (NUM_DRV - k)) - 1));
        exp_done.push_back(c0 + 1 + NUM_DRV * STAGGER_CYC);
        pulse_stop();
        go_to(c0 + 24);
        check("s2_busy_cycles", 32'(busy_cnt), 32'd20);
        expect_drained("s2");

        // 3: start refused without lock
        pll_lock = 1'b0;
        go_to(cyc + 3);
        c0 = cyc;
        busy_cnt = 0;
        exp_err.push_back(c0 + 1);
        pulse_start();
        go_to(c0 + 6);
        check("s3_drv_en", 32'(drv_en), 32'd0);
        check("s3_busy_cycles", 32'(busy_cnt), 32'd0);
        expect_drained("s3");
        pll_lock = 1'b1;
        go_to(cyc + 3);

        // 4: lock loss at drv_en=00111
        c0 = cyc;
        push_up(c0, 3, 1'b0);
        push_drv(c0 + 20, '0);
        exp_err.push_back(c0 + 20);
        pulse_start();
        go_to(c0 + 17);
        pll_lock = 1'b0;
        go_to(c0 + 30);
        check("s4_busy", 32'(seq_busy), 32'd0);
        expect_drained("s4");
        pll_lock = 1'b1;
        go_to(cyc + 3);

        // 5: stop mid ramp-up, start during ramp-down ignored
        c0 = cyc;
        push_up(c0, 2, 1'b0);
        pulse_start();
        go_to(c0 + 15);
        push_drv(c0 + 16, 5'b00001);
        push_drv(c0 + 20, 5'b00000);
        exp_done.push_back(c0 + 24);
        pulse_stop();
        go_to(c0 + 17);
        pulse_start();
        go_to(c0 + 30);
        check("s5_drv_en", 32'(drv_en), 32'd0);
        expect_drained("s5");

        // 6: asynchronous reset mid ramp-up, then a clean restart
        c0 = cyc;
        push_up(c0, 2, 1'b0);
        pulse_start();
        go_to(c0 + 14);
        @(negedge clk);
        #2;
        mon_en = 1'b0;
        rst_l  = 1'b0;
        #1;
        check("s6_async_drv_en", 32'(drv_en), 32'd0);
        check("s6_async_busy",   32'(seq_busy), 32'd0);
        check("s6_async_done",   32'(seq_done), 32'd0);
        check("s6_async_err",    32'(lock_err), 32'd0);
        exp_drv.delete();
        exp_done.delete();
        exp_err.delete();
        @(posedge clk);
        #1;
        rst_l = 1'b1;
        go_to(cyc + 3);
        mon_en = 1'b1;
        c0 = cyc;
        busy_cnt = 0;
        push_up(c0, NUM_DRV, 1'b1);
        pulse_start();
        go_to(c0 + 32);
        check("s6_busy_cycles", 32'(busy_cnt), 32'd28);
        expect_drained("s6");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ctu_2xclk_drv_seq.md
Name: ctu_2xclk_drv_seq

Overview:
- Sequencer for the CTU 2x-clock local driver bank.
- After a start request and PLL lock, it waits a settle interval, then enables the NUM_DRV local clock drivers one at a time at a fixed stagger, which limits di/dt on the clock grid.
- On a stop request it disables the drivers in reverse order.
- On lock loss it shuts all drivers off immediately.
- Sits in the CTU between PLL-lock logic and the 2x-clock local driver enables.

Parameters:
- NUM_DRV, 5, number of local driver enables sequenced.
- LOCK_CYC, 512, settle cycles after start before the first driver enable (min 1).
- STAGGER_CYC, 4, cycles between successive driver enable/disable steps (min 1).
- CNT_W, 10, delay counter width; must hold max(LOCK_CYC, STAGGER_CYC)-1.

Ports:
- clk, input, 1, sequencer clock (free-running reference clock, not the gated 2x clock).
- rst_l, input, 1, asynchronous active-low reset.
- pll_lock, input, 1, PLL lock indicator; asynchronous, synchronized internally.
- start_req, input, 1, one-cycle pulse requesting ramp-up.
- stop_req, input, 1, one-cycle pulse requesting ramp-down.
- drv_en, output, NUM_DRV, per-driver enable; bit 0 is enabled first.
- seq_busy, output, 1, high in SETTLE, RAMP_UP or RAMP_DN.
- seq_done, output, 1, one-cycle pulse when ON is reached or when OFF is reached after a ramp-down.
- lock_err, output, 1, one-cycle pulse on a start refused for no lock, or on lock loss while active.

Behaviour:
- Reset (rst_l low, asynchronous): state OFF, drv_en=0, seq_busy=0, seq_done=0, lock_err=0, counter=0, index=0, both sync flops=0.
- pll_lock passes through a 2-flop synchronizer; lock_s is the second flop output. All decisions use lock_s (2-cycle latency).
- All outputs are registered.
- Index counter idx is $clog2(NUM_DRV) bits. The delay counter decrements and saturates at 0.
- OFF:
  - start_req & lock_s: go to SETTLE, cnt=LOCK_CYC-1.
  - start_req & !lock_s: lock_err pulse, stay in OFF.
  - stop_req: ignored.
  - start_req & stop_req together: treated as stop, so no-op.
- SETTLE:
  - Decrement cnt each cycle.
  - At cnt==0: go to RAMP_UP, set drv_en[0], idx=0, cnt=STAGGER_CYC-1.
- RAMP_UP:
  - cnt==0 & idx<NUM_DRV-1: idx+1, set drv_en[idx+1], reload cnt.
  - cnt==0 & idx==NUM_DRV-1: go to ON, seq_done pulse.
  - stop_req: go to RAMP_DN, clear drv_en[idx] next cycle, reload cnt.
- ON:
  - Hold drv_en all-ones.
  - stop_req: go to RAMP_DN, clear drv_en[NUM_DRV-1], idx=NUM_DRV-1, reload cnt.
- RAMP_DN:
  - cnt==0 & idx>0: idx-1, clear drv_en[idx-1], reload cnt.
  - cnt==0 & idx==0: go to OFF, seq_done pulse.
  - start_req: ignored.
- Lock loss (lock_s==0) in SETTLE, RAMP_UP, ON or RAMP_DN: next cycle drv_en=0, state OFF, lock_err pulse, no seq_done. Lock loss takes priority over stop_req and counter expiry.
- Timing, with start_req at cycle 0 and lock stable:
  - drv_en[k] rises at cycle LOCK_CYC+1+k*STAGGER_CYC.
  - seq_done at cycle LOCK_CYC+1+NUM_DRV*STAGGER_CYC.
- Ramp-down mirrors ramp-up, starting the cycle after stop_req.
- drv_en changes by at most one bit per cycle, except on lock-loss shutdown.
- Reset asserted mid-ramp: drv_en clears asynchronously. No seq_done or lock_err pulse is generated.

Decomposition:
- Package ctu_clk_pkg holds:
  - state enum: OFF, SETTLE, RAMP_UP, ON, RAMP_DN;
  - default constants CTU_2XDRV_NUM=5, CTU_LOCK_CYC=512, CTU_STAGGER_CYC=4.
- One sub-module is natural: ctu_sync2, the generic 2-flop synchronizer with async active-low reset, reset value 0.
- Counter and FSM stay in the top module.

Test Plan (NUM_DRV=5, LOCK_CYC=8, STAGGER_CYC=4):
1. Reset with pll_lock=1 held for 3 cycles, then start_req at cycle 0 -> drv_en =00001@9, 00011@13, 00111@17, 01111@21, 11111@25; seq_done@29; seq_busy high cycles 1-28.
2. From ON, stop_req at cycle 0 -> drv_en =01111@1, 00111@5, 00011@9, 00001@13, 00000@17; seq_done@21.
3. start_req with pll_lock=0 -> lock_err pulse next cycle; drv_en stays 0; state stays OFF.
4. pll_lock deasserted at drv_en=00111 during RAMP_UP -> drv_en=0 exactly 3 cycles later (2 sync + 1 register); lock_err pulse; seq_done never asserts.
5. stop_req 2 cycles after drv_en=00011 appears -> drv_en=00001 next cycle, 00000 4 cycles later, seq_done 4 cycles after that; start_req during RAMP_DN is ignored.
6. rst_l pulsed low mid-RAMP_UP, between clock edges -> drv_en=0 immediately, before the next edge; all pulses low; a new start after reset follows the scenario-1 timing.
